// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: holds one FP instruction toward the FPU until f_ready and owns fcsr.
// Optional BUSY watchdog enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [7:0]  req_funct7,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_load_data,
    input  logic        csr_we,
    input  logic [7:0]  csr_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic        illegal_rm,
    output logic [7:0]  fcsr,
    output logic        timeout_err,
    output logic [4:0]  f_rs1,
    output logic [4:0]  f_rs2,
    output logic [4:0]  f_rd,
    output logic [7:0]  f_funct_7,
    output logic [2:0]  frm_in,
    output logic        f_LW,
    output logic        f_SW,
    output logic [31:0] dload_ext,
    input  logic [31:0] FPU_all_out,
    input  logic [4:0]  f_flags,
    input  logic        f_ready
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;

    state_e     state;
    logic [2:0] frm;
    logic [4:0] fflags;
    logic [2:0] eff_rm;
    logic       rm_bad;
    logic       busy_arith;
    logic       accum;
    logic       finish;
    logic       tmo_hit;

    assign fcsr   = {frm, fflags};
    assign eff_rm = (req_rm == 3'b111) ? frm : req_rm;
    assign rm_bad = (eff_rm >= 3'b101);

    // Load/store strobes are held as levels in BUSY, so they identify the in-flight op class.
    assign busy_arith = !f_LW && !f_SW;
    assign accum      = (state == StBusy) && f_ready && busy_arith;
    assign finish     = (state == StBusy) && (f_ready || tmo_hit);

    assign stall = n_rst && ((state == StBusy) || ((state == StIdle) && req_valid));

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] tmo_cnt;

    // f_ready in the limit cycle takes priority, so the hit requires it low.
    assign tmo_hit = (state == StBusy) && !f_ready && (tmo_cnt == CntLast);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (state == StIdle) begin
                tmo_cnt <= '0;
            end else if ((state == StBusy) && !f_ready) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= StIdle;
            frm        <= 3'b000;
            fflags     <= 5'b00000;
            result     <= 32'h0;
            done       <= 1'b0;
            illegal_rm <= 1'b0;
            f_rs1      <= 5'd0;
            f_rs2      <= 5'd0;
            f_rd       <= 5'd0;
            f_funct_7  <= 8'h00;
            frm_in     <= 3'b000;
            f_LW       <= 1'b0;
            f_SW       <= 1'b0;
            dload_ext  <= 32'h0;
        end else begin
            done       <= 1'b0;
            illegal_rm <= 1'b0;

            if (csr_we) begin
                frm    <= csr_wdata[7:5];
                fflags <= csr_wdata[4:0] | (accum ? f_flags : 5'b00000);
            end else if (accum) begin
                fflags <= fflags | f_flags;
            end

            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        if (rm_bad) begin
                            illegal_rm <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            f_rs1     <= req_rs1;
                            f_rs2     <= req_rs2;
                            f_rd      <= req_rd;
                            f_funct_7 <= req_funct7;
                            frm_in    <= eff_rm;
                            f_LW      <= (req_op == OpLoad);
                            f_SW      <= (req_op == OpStore);
                            dload_ext <= (req_op == OpLoad) ? req_load_data : 32'h0;
                            state     <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (finish) begin
                        result    <= f_ready ? FPU_all_out : 32'h0;
                        done      <= 1'b1;
                        f_rs1     <= 5'd0;
                        f_rs2     <= 5'd0;
                        f_rd      <= 5'd0;
                        f_funct_7 <= 8'h00;
                        frm_in    <= 3'b000;
                        f_LW      <= 1'b0;
                        f_SW      <= 1'b0;
                        dload_ext <= 32'h0;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level fcsr/result model.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic [7:0]  req_funct7 = '0;
  logic [2:0]  req_rm = '0;
  logic [31:0] req_load_data = '0;
  logic        csr_we = 1'b0;
  logic [7:0]  csr_wdata = '0;
  logic        stall, done, illegal_rm, timeout_err;
  logic [31:0] result;
  logic [7:0]  fcsr;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [7:0]  f_funct_7;
  logic [2:0]  frm_in;
  logic        f_LW, f_SW;
  logic [31:0] dload_ext;
  logic [31:0] FPU_all_out = '0;
  logic [4:0]  f_flags = '0;
  logic        f_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0]  m_frm;
  logic [4:0]  m_fflags;
  logic [31:0] m_result;

  logic [59:0] bus;
  assign bus = {f_rs1, f_rs2, f_rd, f_funct_7, frm_in, f_LW, f_SW, dload_ext};

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_funct7(req_funct7),
    .req_rm(req_rm), .req_load_data(req_load_data), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .stall(stall), .done(done), .result(result),
    .illegal_rm(illegal_rm), .fcsr(fcsr), .timeout_err(timeout_err),
    .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .f_funct_7(f_funct_7),
    .frm_in(frm_in), .f_LW(f_LW), .f_SW(f_SW), .dload_ext(dload_ext),
    .FPU_all_out(FPU_all_out), .f_flags(f_flags), .f_ready(f_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [7:0] w);
    csr_we    = 1'b1;
    csr_wdata = w;
    tick();
    csr_we   = 1'b0;
    m_frm    = w[7:5];
    m_fflags = w[4:0];
    chk("csr_write_fcsr", fcsr, {m_frm, m_fflags});
  endtask

  // One instruction: accept, `delay` cycles without f_ready, then completion.
  // csr_k = -1 writes fcsr in the accept cycle, 0..delay in that BUSY cycle, else no write.
  task automatic do_op(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [7:0] f7, input logic [2:0] rm,
                       input logic [31:0] ld, input int delay, input logic [31:0] res,
                       input logic [4:0] flags, input int csr_k, input logic [7:0] csr_w);
    logic [2:0]  eff;
    logic        arith;
    logic        is_ld;
    logic        is_st;
    logic [59:0] exp_bus;
    eff   = (rm == 3'b111) ? m_frm : rm;
    is_ld = (op == 2'b01);
    is_st = (op == 2'b10);
    arith = !is_ld && !is_st;

    req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_funct7 = f7;
    req_rm = rm; req_load_data = ld; req_valid = 1'b1;
    csr_we = (csr_k == -1);
    csr_wdata = csr_w;
    #1;
    chk("stall_on_request", stall, 1'b1);
    @(posedge clk);
    if (csr_k == -1) begin
      m_frm    = csr_w[7:5];
      m_fflags = csr_w[4:0];
    end
    #1;
    req_valid = 1'b0;
    csr_we = 1'b0;
    req_rs1 = 5'($urandom); req_funct7 = 8'($urandom); req_load_data = $urandom;

    if (eff >= 3'b101) begin
      chk("illegal_rm_pulse", illegal_rm, 1'b1);
      chk("illegal_done", done, 1'b1);
      chk("illegal_bus_idle", bus, 60'h0);
      chk("illegal_fcsr", fcsr, {m_frm, m_fflags});
      tick();
      chk("illegal_pulse_end", {illegal_rm, done}, 2'b00);
      return;
    end

    exp_bus = {rs1, rs2, rd, f7, eff, is_ld, is_st, is_ld ? ld : 32'h0};
    for (int k = 0; k <= delay; k++) begin
      chk("busy_bus", bus, exp_bus);
      chk("busy_stall", stall, 1'b1);
      chk("busy_done", done, 1'b0);
      chk("busy_result_hold", result, m_result);
      f_ready     = (k == delay);
      FPU_all_out = (k == delay) ? res : $urandom;
      f_flags     = (k == delay) ? flags : 5'($urandom);
      csr_we      = (k == csr_k);
      csr_wdata   = csr_w;
      @(posedge clk);
      if (k == csr_k) begin
        m_frm    = csr_w[7:5];
        m_fflags = csr_w[4:0] | ((k == delay && arith) ? flags : 5'b0);
      end else if (k == delay && arith) begin
        m_fflags = m_fflags | flags;
      end
      if (k == delay) m_result = res;
      #1;
      f_ready = 1'b0;
      csr_we  = 1'b0;
      chk("busy_fcsr", fcsr, {m_frm, m_fflags});
    end
    chk("done_pulse", done, 1'b1);
    chk("done_bus_cleared", bus, 60'h0);
    chk("done_stall", stall, 1'b0);
    chk("done_result", result, m_result);
    chk("done_no_timeout", timeout_err, 1'b0);
    tick();
    chk("done_pulse_end", done, 1'b0);
  endtask

  initial begin
    m_frm = 3'b000; m_fflags = 5'b0; m_result = 32'h0;
    #2;
    chk("reset_outputs", {stall, done, illegal_rm, timeout_err, fcsr, result, bus},
        {4'b0, 8'h00, 32'h0, 60'h0});
    #10 n_rst = 1'b1;
    tick();

    // Directed: plain arith with f_ready in cycle 3, then sticky flag OR.
    do_op(2'b00, 5'd3, 5'd4, 5'd5, 8'h00, 3'b000, 32'h0, 2, 32'h3F800000, 5'b00001, -2, 8'h0);
    chk("first_fflags", fcsr[4:0], 5'b00001);
    do_op(2'b00, 5'd6, 5'd7, 5'd8, 8'h08, 3'b001, 32'h0, 0, 32'h40000000, 5'b10000, -2, 8'h0);
    chk("sticky_fflags", fcsr[4:0], 5'b10001);

    // Dynamic rm resolving to a reserved mode.
    csr_write({3'b101, m_fflags});
    do_op(2'b00, 5'd1, 5'd2, 5'd3, 8'h10, 3'b111, 32'h0, 0, 32'h0, 5'b0, -2, 8'h0);
    chk("illegal_fflags_kept", fcsr, 8'b101_10001);
    csr_write({3'b010, m_fflags});

    // FLW: load data forwarded, flags ignored.
    do_op(2'b01, 5'd0, 5'd0, 5'd9, 8'h70, 3'b111, 32'hDEADBEEF, 1, 32'hDEADBEEF, 5'b11111,
          -2, 8'h0);
    chk("flw_fflags_unchanged", fcsr, 8'b010_10001);

    // Reset in the middle of BUSY.
    req_op = 2'b00; req_rs1 = 5'd11; req_rs2 = 5'd12; req_rd = 5'd13; req_funct7 = 8'h04;
    req_rm = 3'b000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pre_reset_busy", f_rs1, 5'd11);
    tick();
    n_rst = 1'b0;
    #1;
    chk("mid_busy_reset", {stall, done, illegal_rm, timeout_err, fcsr, result, bus},
        {4'b0, 8'h00, 32'h0, 60'h0});
    m_frm = 3'b000; m_fflags = 5'b0; m_result = 32'h0;
    #2 n_rst = 1'b1;
    tick();
    chk("post_reset_idle", {stall, done, bus}, 62'h0);
    do_op(2'b10, 5'd14, 5'd15, 5'd0, 8'h0, 3'b011, 32'h12345678, 1, 32'hCAFEF00D, 5'b00100,
          -2, 8'h0);

    // Randomized transactions, including CSR writes racing completion.
    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 8'($urandom),
            3'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom, 5'($urandom),
            int'($urandom_range(0, 7)) - 2, 8'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    csr_write(8'h00);
    req_op = 2'b00; req_rs1 = 5'd2; req_rm = 3'b000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("tmo_busy_stall", stall, 1'b1);
      FPU_all_out = $urandom;
      f_flags = 5'($urandom);
      tick();
    end
    m_result = 32'h0;
    chk("tmo_err", {timeout_err, done}, 2'b11);
    chk("tmo_result", result, m_result);
    chk("tmo_fflags", fcsr, 8'h00);
    tick();
    chk("tmo_pulse_end", {timeout_err, done}, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Core-side initiator for the FPU interface: accepts one decoded floating-point instruction at a time from the pipeline and drives the register selects, funct7, rounding mode, load data and load/store strobes toward the FPU. It holds those signals stable until the FPU asserts f_ready, stalls the pipeline while busy, and captures the result. It also owns the fcsr state: frm for dynamic rounding and sticky fflags accumulated from f_flags.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: BUSY-cycle limit before abort (used only with the timeout feature).

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  decoded FP instruction present
- req_op  in  2  00 arith, 01 load (FLW), 10 store (FSW), 11 reserved (treated as arith)
- req_rs1, req_rs2, req_rd  in  5 each  register selects
- req_funct7  in  8  operation select
- req_rm  in  3  instruction rm field; 3'b111 = dynamic
- req_load_data  in  32  memory data for FLW
- csr_we  in  1  fcsr write
- csr_wdata  in  8  {frm[2:0], fflags[4:0]}
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- result  out  32  captured FPU_all_out
- illegal_rm  out  1  one-cycle pulse, reserved rounding mode
- fcsr  out  8  {frm, fflags}
- timeout_err  out  1  one-cycle abort pulse
- f_rs1, f_rs2, f_rd  out  5 each; f_funct_7  out  8; frm_in  out  3; f_LW, f_SW  out  1; dload_ext  out  32  FPU-side drive
- FPU_all_out  in  32; f_flags  in  5; f_ready  in  1  FPU responses

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, req_valid=1:
  - Effective rm = fcsr.frm if req_rm==111, else req_rm.
  - Effective rm in {101,110,111}: illegal_rm=1 and done=1 in the next cycle; no FPU activity; stay in IDLE.
  - Otherwise: latch all req_* fields into issue registers and go to BUSY.
  - stall is combinationally high whenever req_valid=1 in IDLE.
- BUSY:
  - Drive outputs from the issue registers. f_LW is high for load and f_SW for store, held as levels.
  - dload_ext = latched load data for loads, else 0.
  - stall=1.
  - When f_ready=1: result <= FPU_all_out; for arith only, fflags <= fflags | f_flags (load/store never raise flags); go to DONE.
- DONE: done=1, stall=0; f_LW, f_SW and all f_* outputs drop to 0; next state is IDLE. A new request cannot be accepted in DONE.
- f_ready outside BUSY is ignored.
- CSR write: fcsr <= csr_wdata at any time. If it coincides with flag accumulation, fflags <= csr_wdata[4:0] | f_flags.
- frm changes after latch do not affect the in-flight op.
- result holds its value until the next capture.

## Timing
- Reset (async, n_rst=0):
  - State returns to IDLE.
  - fcsr, result, all f_* outputs, stall, done, illegal_rm and timeout_err = 0.
  - Reset during BUSY aborts the operation with no flag update.
- Minimum latency: request accepted in cycle 0, FPU signals valid in cycle 1, f_ready in cycle 1, done in cycle 2.
- Interface signals are registered and stable for the whole BUSY interval.

## Configuration
- FPU_ISSUE_TIMEOUT_EN defined:
  - A counter is cleared on BUSY entry and incremented each BUSY cycle without f_ready.
  - When the count reaches TIMEOUT_CYCLES: go to DONE with timeout_err=1 alongside done; result = 0; no flag update.
  - f_ready in the same cycle as the limit wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; timeout_err is tied to 0.

## Test plan
- Arith op, rs1=3, rs2=4, rd=5, funct7=0x00, rm=000; f_ready in cycle 3 with FPU_all_out=0x3F800000, f_flags=00001 -> f_* signals stable in cycles 1-3, done in cycle 4, result=0x3F800000, fflags=00001.
- Second arith op returns f_flags=10000 -> fflags=10001 (sticky OR).
- fcsr frm=101, request with req_rm=111 -> illegal_rm and done the next cycle; f_* stay 0; fflags unchanged.
- FLW with req_load_data=0xDEADBEEF -> f_LW=1 and dload_ext=0xDEADBEEF during BUSY; f_flags=11111 returned -> fflags unchanged.
- Assert n_rst=0 mid-BUSY -> all outputs 0 immediately; later request proceeds normally.
- With FPU_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=8, f_ready never asserted -> timeout_err and done after 8 BUSY cycles, result=0.
